alu_op_sequencer: RTL and testbench

Command front-end and result collector for the ALU. Accepts one operation at a time over a valid/ready handshake and decodes `ALU_FUN[3:2]` into a one-cycle enable for the arithmetic, logic, compare or shift unit. It holds `A`, `B` and `ALU_FUN` stable while the unit works, captures the unit's registered output when that unit's flag rises, and presents the result downstream with a valid/ready handshake. A missing flag is detected by timeout.

---
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: one-at-a-time ALU command issue, result capture and timeout.
module alu_op_sequencer #(
    parameter int width   = 16,
    parameter int TIMEOUT = 4
) (
    input  logic             clock,
    input  logic             rest,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_fun,
    input  logic [width-1:0] cmd_a,
    input  logic [width-1:0] cmd_b,
    output logic [width-1:0] A,
    output logic [width-1:0] B,
    output logic [3:0]       ALU_FUN,
    output logic             arith_enable,
    output logic             logic_enable,
    output logic             cmp_enable,
    output logic             shift_enable,
    input  logic             arith_flag,
    input  logic             logic_flag,
    input  logic             cmp_flag,
    input  logic             shift_flag,
    input  logic [width-1:0] arith_out,
    input  logic [width-1:0] logic_out,
    input  logic [width-1:0] cmp_out,
    input  logic [width-1:0] shift_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [width-1:0] res_data,
    output logic             res_err,
    output logic [15:0]      op_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    state_t           state_q, state_d;
    logic [width-1:0] a_q, a_d, b_q, b_d, res_data_q, res_data_d, sel_out;
    logic [3:0]       fun_q, fun_d, en_q, en_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      op_count_q, op_count_d;
    logic             res_err_q, res_err_d, sel_flag;
    always_ff @(posedge clock) begin
        if (rest) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            en_q       <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            fun_q      <= fun_d;
            en_q       <= en_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            op_count_q <= op_count_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        fun_d      = fun_q;
        en_d       = '0;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                a_d     = cmd_a;
                b_d     = cmd_b;
                fun_d   = cmd_fun;
                en_d    = 4'(1) << cmd_fun[3:2];
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // only the unit selected by the latched opcode can end the wait
                if (sel_flag) begin
                    res_data_d = sel_out;
                    res_err_d  = 1'b0;
                    state_d    = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: if (res_ready) begin
                op_count_d = op_count_q + 16'd1;
                state_d    = IDLE;
            end
        endcase
    end
    always_comb begin
        cmd_ready = state_q == IDLE;
        res_valid = state_q == DONE;
        A         = a_q;
        B         = b_q;
        ALU_FUN   = fun_q;
        res_data  = res_data_q;
        res_err   = res_err_q;
        op_count  = op_count_q;
        {shift_enable, cmp_enable, logic_enable, arith_enable} = en_q;
        sel_flag  = fun_q[3] ? (fun_q[2] ? shift_flag : cmp_flag) : (fun_q[2] ? logic_flag : arith_flag);
        sel_out   = fun_q[3] ? (fun_q[2] ? shift_out : cmp_out) : (fun_q[2] ? logic_out : arith_out);
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of issue, capture, backpressure, timeout, reset and count wrap.
module tb_alu_op_sequencer;
    logic        clock = 1'b0, rest = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, res_ready = 1'b0;
    logic [3:0]  cmd_fun = '0, ALU_FUN;
    logic [15:0] cmd_a = '0, cmd_b = '0, A, B;
    logic        arith_enable, logic_enable, cmp_enable, shift_enable;
    logic        arith_flag, logic_flag, cmp_flag, shift_flag;
    logic [15:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
    logic        res_valid, res_err;
    logic [15:0] res_data, op_count;
    logic [3:0]  ufl = '0, mute = '0, noise = '0, en_w;
    int          tests = 0, fails = 0;

    alu_op_sequencer #(.width(16), .TIMEOUT(4)) dut (
        .clock(clock), .rest(rest), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_fun(cmd_fun), .cmd_a(cmd_a), .cmd_b(cmd_b), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .arith_enable(arith_enable), .logic_enable(logic_enable),
        .cmp_enable(cmp_enable), .shift_enable(shift_enable),
        .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
        .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .op_count(op_count)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] unit_fn(input logic [1:0] u, input logic [15:0] a, input logic [15:0] b);
        case (u)
            2'd0:    return a + b;
            2'd1:    return a & b;
            2'd2:    return {15'd0, a < b};
            default: return a << b[3:0];
        endcase
    endfunction

    // Unit models: flag and result registered one edge after the enable.
    assign en_w = {shift_enable, cmp_enable, logic_enable, arith_enable};
    assign {shift_flag, cmp_flag, logic_flag, arith_flag} = ufl | noise;
    always @(posedge clock) begin
        ufl       <= en_w & ~mute;
        arith_out <= unit_fn(2'd0, A, B);
        logic_out <= unit_fn(2'd1, A, B);
        cmp_out   <= unit_fn(2'd2, A, B);
        shift_out <= unit_fn(2'd3, A, B);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        cmd_valid = 1'b1;
        cmd_fun   = f;
        cmd_a     = a;
        cmd_b     = b;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_fun", ALU_FUN, 0);
        chk("rst_en", en_w, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_err", res_err, 0);
        chk("rst_data", res_data, 0);
        chk("rst_count", op_count, 0);
        chk("rst_ready", cmd_ready, 1);
        rest = 1'b0;
        step();
        // shift example
        issue(4'b1101, 16'h0003, 16'h8001);
        chk("sh_en_issue", en_w, 4'b1000);
        chk("sh_ready_issue", cmd_ready, 0);
        chk("sh_fun", ALU_FUN, 4'hD);
        chk("sh_A", A, 16'h0003);
        chk("sh_B", B, 16'h8001);
        step();
        chk("sh_en_wait", en_w, 0);
        chk("sh_valid_wait", res_valid, 0);
        step();
        chk("sh_valid", res_valid, 1);
        chk("sh_data", res_data, 16'h0006);
        chk("sh_err", res_err, 0);
        handshake();
        chk("sh_count", op_count, 1);
        chk("sh_ready_after", cmd_ready, 1);
        chk("sh_valid_after", res_valid, 0);
        // decode sweep with every other unit's flag held high
        for (int u = 0; u < 4; u++) begin
            noise = ~(4'(1) << u);
            issue({u[1:0], 2'b10}, 16'h1234 + 16'(u), 16'h0F0F);
            chk("sw_en_issue", en_w, 4'(1) << u);
            step();
            chk("sw_en_wait", en_w, 0);
            chk("sw_valid_wait", res_valid, 0);
            step();
            chk("sw_valid", res_valid, 1);
            chk("sw_data", res_data, unit_fn(u[1:0], 16'h1234 + 16'(u), 16'h0F0F));
            chk("sw_err", res_err, 0);
            handshake();
            noise = '0;
            chk("sw_count", op_count, 32'(2 + u));
        end
        // timeout: selected logic unit silent, others flag continuously
        mute  = 4'b0010;
        noise = 4'b1101;
        issue(4'b0100, 16'h0001, 16'h0001);
        step();
        step();
        step();
        step();
        chk("to_valid_early", res_valid, 0);
        step();
        chk("to_valid", res_valid, 1);
        chk("to_err", res_err, 1);
        chk("to_data", res_data, 0);
        handshake();
        chk("to_count", op_count, 6);
        mute  = '0;
        noise = '0;
        // backpressure with a competing command offered
        issue(4'b0001, 16'h0100, 16'h0023);
        step();
        step();
        chk("bp_valid0", res_valid, 1);
        chk("bp_data0", res_data, 16'h0123);
        cmd_valid = 1'b1;
        cmd_fun   = 4'b1000;
        cmd_a     = 16'h0003;
        cmd_b     = 16'h0005;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 16'h0123);
            chk("bp_ready", cmd_ready, 0);
            chk("bp_A", A, 16'h0100);
        end
        handshake();
        chk("bp_count", op_count, 7);
        chk("bp_ready_idle", cmd_ready, 1);
        chk("bp_valid_idle", res_valid, 0);
        step();
        cmd_valid = 1'b0;
        chk("bp_cmp_en", en_w, 4'b0100);
        chk("bp_A_new", A, 16'h0003);
        step();
        step();
        chk("bp_cmp_data", res_data, 16'h0001);
        handshake();
        chk("bp_count2", op_count, 8);
        // reset during WAIT, then a late flag
        mute = 4'b0001;
        issue(4'b0000, 16'h0011, 16'h0022);
        step();
        rest = 1'b1;
        step();
        rest = 1'b0;
        chk("mr_ready", cmd_ready, 1);
        chk("mr_valid", res_valid, 0);
        chk("mr_count", op_count, 0);
        chk("mr_en", en_w, 0);
        noise = 4'b0001;
        step();
        chk("mr_late_valid", res_valid, 0);
        step();
        chk("mr_late_valid2", res_valid, 0);
        chk("mr_late_ready", cmd_ready, 1);
        noise = '0;
        mute  = '0;
        // op_count wrap
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        chk("wr_pre", op_count, 16'hFFFF);
        issue(4'b0000, 16'h0002, 16'h0003);
        step();
        step();
        chk("wr_data", res_data, 16'h0005);
        handshake();
        chk("wr_count", op_count, 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
